moment_ram_scanner: RTL and testbench

MOMENT_RAM_SCANNER -- requirements
Module: moment_ram_scanner

---
 rtl/moment_ram_scanner.sv | 143 ++++++++++++++
 tb/tb_moment_ram_scanner.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moment_ram_scanner.sv
// Moment RAM scanner: sweeps a row-major NX x NY moment RAM either streaming
// every word out over a valid/ready port (read sweep) or writing a constant
// into every word (fill sweep).
module moment_ram_scanner #(
    parameter int unsigned NX            = 16,
    parameter int unsigned NY            = 16,
    parameter int unsigned DEPTH         = NX * NY,
    parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           start,
    input  logic                           clear,
    input  logic signed [DATA_WIDTH-1:0]   fill_value,
    output logic [ADDRESS_WIDTH-1:0]       address,
    output logic                           WE,
    output logic signed [DATA_WIDTH-1:0]   data_in,
    input  logic signed [DATA_WIDTH-1:0]   ram_data_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(NX)-1:0]          out_x,
    output logic [$clog2(NY)-1:0]          out_y,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned XW = $clog2(NX);
    localparam int unsigned YW = $clog2(NY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;

    logic              last_addr;
    logic              load;
    logic              step;
    logic              restart;
    logic              pop;

    // Fill data is a straight pass-through of the requested value.
    assign data_in   = fill_value;
    assign last_addr = (address == ADDRESS_WIDTH'(DEPTH - 1));

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = clear ? S_FILL : S_READ;
            S_READ:  if (load && last_addr) next_state = S_DRAIN;
            S_DRAIN: if (out_valid && out_ready) next_state = S_DONE;
            S_FILL:  if (last_addr) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Per-cycle datapath strobes derived from the current state.
    always_comb begin
        load    = 1'b0;
        step    = 1'b0;
        restart = 1'b0;
        pop     = 1'b0;
        case (state)
            S_IDLE:  restart = start;
            S_READ: begin
                load = !out_valid || out_ready;
                step = load;
            end
            S_DRAIN: pop  = out_valid && out_ready;
            S_FILL:  step = 1'b1;
            default: ;
        endcase
    end

    // Status flags registered from the upcoming state so they align with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            WE   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            WE   <= (next_state == S_FILL);
            busy <= (next_state != S_IDLE);
            done <= (next_state == S_DONE);
        end
    end

    // Row-major x/y walk with a matching linear address (no divide needed).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            address <= '0;
            x       <= '0;
            y       <= '0;
        end else if (restart) begin
            address <= '0;
            x       <= '0;
            y       <= '0;
        end else if (step) begin
            address <= last_addr ? '0 : address + ADDRESS_WIDTH'(1);
            if (x == XW'(NX - 1)) begin
                x <= '0;
                y <= (y == YW'(NY - 1)) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Output stream register: load on a free slot, clear after the final pop.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ram_data_out;
            out_x     <= x;
            out_y     <= y;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moment_ram_scanner.sv
// Self-checking bench for moment_ram_scanner with a behavioural RAM and a
// reference model of the expected word stream.
module tb_moment_ram_scanner;

    localparam int NX    = 16;
    localparam int NY    = 16;
    localparam int DEPTH = NX * NY;
    localparam int AW    = 8;
    localparam int DW    = 32;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 start;
    logic                 clear;
    logic signed [DW-1:0] fill_value;
    logic [AW-1:0]        address;
    logic                 WE;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] ram_data_out;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic [3:0]           out_x;
    logic [3:0]           out_y;
    logic                 busy;
    logic                 done;

    int checks   = 0;
    int failures = 0;

    // Behavioural RAM: DUT write port has priority over the bench preload port.
    logic signed [DW-1:0] mem [DEPTH];
    logic                 tb_we;
    logic [AW-1:0]        tb_addr;
    logic signed [DW-1:0] tb_wdata;
    int                   ref_mem [DEPTH];

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (WE)         mem[address] <= data_in;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
    end
    assign ram_data_out = mem[address];

    moment_ram_scanner #(.NX(NX), .NY(NY)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .clear(clear),
        .fill_value(fill_value), .address(address), .WE(WE), .data_in(data_in),
        .ram_data_out(ram_data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
    );

    // Results of the most recent read sweep.
    int q_d[$];
    int q_x[$];
    int q_y[$];
    int first_valid, last_valid, done_cnt, done_cyc, last_hs, stall_err, we_seen, busy_at1;

    task automatic preload(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            int v;
            v = (kind == 0) ? (i - 128) : int'($urandom);
            @(negedge Clk);
            tb_we = 1'b1; tb_addr = AW'(i); tb_wdata = v;
            ref_mem[i] = v;
        end
        @(negedge Clk);
        tb_we = 1'b0;
    endtask

    // Drive one read sweep; mode 0 ready high, 1 pattern 1,0,0,1, 2 random.
    task automatic run_read(input int mode, input int inject_addr);
        logic prev_stall;
        int   pd, px, py;
        bit   rdy, injected;
        q_d.delete(); q_x.delete(); q_y.delete();
        first_valid = -1; last_valid = -1; done_cnt = 0; done_cyc = -1;
        last_hs = -1; stall_err = 0; we_seen = 0; busy_at1 = 0;
        prev_stall = 1'b0; pd = 0; px = 0; py = 0; injected = 0;
        @(negedge Clk);
        start = 1'b1; clear = 1'b0; out_ready = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = 1'b0; clear = 1'b0;
            if (inject_addr >= 0 && !injected && int'(address) == inject_addr) begin
                start = 1'b1; clear = 1'b1; injected = 1;
            end
            if (cyc == 1) busy_at1 = int'(busy);
            if (WE) we_seen++;
            if (prev_stall && !(out_valid && int'(out_data) == pd && int'(out_x) == px && int'(out_y) == py))
                stall_err++;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid && rdy) begin
                q_d.push_back(int'(out_data)); q_x.push_back(int'(out_x)); q_y.push_back(int'(out_y));
                last_hs = cyc;
            end
            prev_stall = out_valid && !rdy;
            pd = int'(out_data); px = int'(out_x); py = int'(out_y);
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(negedge Clk);
        end
        start = 1'b0; clear = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        fill_value = DW'($urandom);
        repeat (2) @(negedge Clk);
        checks++;
        if ({address, WE, out_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: addr=%0d we=%0b valid=%0b busy=%0b done=%0b, expected all 0",
                     address, WE, out_valid, busy, done);
        end
        checks++;
        if (out_data !== 0 || out_x !== 0 || out_y !== 0) begin
            failures++;
            $display("FAIL reset_out: data=%0d x=%0d y=%0d, expected 0", out_data, out_x, out_y);
        end
        checks++;
        if (data_in !== fill_value) begin
            failures++;
            $display("FAIL data_in_pass: got %0d expected %0d", data_in, fill_value);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    // Common stream-content comparisons against the reference model.
    task automatic check_stream(input string tag);
        checks++;
        if (q_d.size() != DEPTH) begin
            failures++;
            $display("FAIL %s_count: got %0d words expected %0d", tag, q_d.size(), DEPTH);
        end
        for (int k = 0; k < q_d.size() && k < DEPTH; k++) begin
            checks++;
            if (q_d[k] !== ref_mem[k] || q_x[k] !== k % NX || q_y[k] !== k / NX) begin
                failures++;
                $display("FAIL %s_word%0d: got d=%0d x=%0d y=%0d expected d=%0d x=%0d y=%0d",
                         tag, k, q_d[k], q_x[k], q_y[k], ref_mem[k], k % NX, k / NX);
            end
        end
        checks++;
        if (done_cnt != 1 || we_seen != 0) begin
            failures++;
            $display("FAIL %s_done: got done_pulses=%0d we_cycles=%0d expected 1 and 0", tag, done_cnt, we_seen);
        end
    endtask

    task automatic test_read_basic;
        preload(0);
        run_read(0, -1);
        check_stream("read");
        checks++;
        if (first_valid != 2 || last_valid != DEPTH + 1 || done_cyc != DEPTH + 2) begin
            failures++;
            $display("FAIL read_latency: got valid %0d..%0d done %0d expected 2..%0d done %0d",
                     first_valid, last_valid, done_cyc, DEPTH + 1, DEPTH + 2);
        end
        checks++;
        if (busy_at1 != 1) begin
            failures++;
            $display("FAIL read_busy: got %0d expected 1", busy_at1);
        end
    endtask

    task automatic test_backpressure(input int mode, input string tag);
        run_read(mode, -1);
        check_stream(tag);
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL %s_stable: got %0d unstable stall cycles expected 0", tag, stall_err);
        end
        checks++;
        if (done_cyc != last_hs + 1) begin
            failures++;
            $display("FAIL %s_done_time: got done %0d expected %0d", tag, done_cyc, last_hs + 1);
        end
    endtask

    task automatic test_start_ignored;
        run_read(0, 100);
        check_stream("ignore");
        checks++;
        if (done_cyc != DEPTH + 2) begin
            failures++;
            $display("FAIL ignore_latency: got done %0d expected %0d", done_cyc, DEPTH + 2);
        end
    endtask

    task automatic test_fill;
        int we_cnt, we_first, we_last, vseen, dcnt, dcyc;
        we_cnt = 0; we_first = -1; we_last = -1; vseen = 0; dcnt = 0; dcyc = -1;
        @(negedge Clk);
        start = 1'b1; clear = 1'b1; fill_value = -5;
        @(negedge Clk);
        start = 1'b0; clear = 1'b0;
        for (int cyc = 1; cyc < 1000; cyc++) begin
            if (WE) begin
                we_cnt++; we_last = cyc;
                if (we_first < 0) we_first = cyc;
            end
            if (out_valid) vseen++;
            if (done) begin dcnt++; dcyc = cyc; end
            if (dcyc >= 0 && cyc >= dcyc + 3) break;
            @(negedge Clk);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = -5;
        checks++;
        if (we_cnt != DEPTH || we_first != 1 || we_last != DEPTH) begin
            failures++;
            $display("FAIL fill_we: got %0d cycles %0d..%0d expected %0d cycles 1..%0d",
                     we_cnt, we_first, we_last, DEPTH, DEPTH);
        end
        checks++;
        if (dcnt != 1 || dcyc != DEPTH + 1 || vseen != 0) begin
            failures++;
            $display("FAIL fill_done: got pulses=%0d at %0d valid_cycles=%0d expected 1 at %0d, 0",
                     dcnt, dcyc, vseen, DEPTH + 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                failures++;
                $display("FAIL fill_mem%0d: got %0d expected %0d", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill;
        int guard, dcnt;
        dcnt = 0;
        @(negedge Clk);
        start = 1'b1; clear = 1'b1; fill_value = 7;
        @(negedge Clk);
        start = 1'b0; clear = 1'b0;
        guard = 0;
        while (!(WE && address == AW'(50)) && guard < 500) begin
            @(negedge Clk);
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            failures++;
            $display("FAIL abort_reach: got timeout expected address 50 in fill");
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (WE !== 1'b0 || busy !== 1'b0 || address !== '0) begin
            failures++;
            $display("FAIL abort_now: got we=%0b busy=%0b addr=%0d expected 0,0,0", WE, busy, address);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (done) dcnt++;
            if (i == 1) Reset = 1'b0;
        end
        checks++;
        if (dcnt != 0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_done: got pulses=%0d busy=%0b expected 0,0", dcnt, busy);
        end
        for (int i = 0; i < 50; i++) ref_mem[i] = 7;
        run_read(0, -1);
        check_stream("after_abort");
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; clear = 1'b0; fill_value = '0;
        out_ready = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
        test_reset;
        test_read_basic;
        test_backpressure(1, "toggle");
        preload(1);
        test_backpressure(2, "random");
        test_start_ignored;
        test_fill;
        test_reset_mid_fill;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
